// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, transaction owners,
// and the grant decision used when both requesters compete for the bus.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Priority side wins a contended grant unless it has already used up its streak.
    function automatic owner_e pick_owner(input logic if_req, input logic d_req,
                                          input logic data_priority, input logic streak_full);
        owner_e pri_side;
        owner_e oth_side;
        pri_side = data_priority ? OWN_D : OWN_IF;
        oth_side = data_priority ? OWN_IF : OWN_D;
        if (if_req && d_req) begin
            return streak_full ? oth_side : pri_side;
        end
        return d_req ? OWN_D : OWN_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-bus handshake signals of the arbiter; the tristate data
// bus stays a plain port on the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE = mem_port_arbiter_pkg::WORD_SIZE_DEFAULT
);
    logic                 if_req;
    logic [WORD_SIZE-1:0] if_addr;
    logic                 if_ready;
    logic [WORD_SIZE-1:0] if_rdata;

    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic                 d_ready;
    logic [WORD_SIZE-1:0] d_rdata;

    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic                 inputReady;
    logic                 ackOutput;

    logic                 busy;
    logic                 timeout_err;

    // Requesters plus external memory: drive requests and memory handshakes.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, inputReady, ackOutput,
        input  if_ready, if_rdata, d_ready, d_rdata, readM, writeM, address, busy, timeout_err
    );

    // The arbiter itself.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, inputReady, ackOutput,
        output if_ready, if_rdata, d_ready, d_rdata, readM, writeM, address, busy, timeout_err
    );

endinterface

// File: rtl/mem_timeout_counter.sv
// Counts bus cycles spent waiting for a memory handshake; expired marks the
// TIMEOUT-th waiting cycle so the FSM can abort on that edge.
module mem_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto one memory bus using
// request/ready handshakes, a fairness streak limit and a timeout guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE     = WORD_SIZE_DEFAULT,
    parameter int TIMEOUT       = 15,
    parameter bit DATA_PRIORITY = 1'b1,
    parameter int MAX_STREAK    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus,
    inout  wire  [WORD_SIZE-1:0] data
);

    localparam int STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);

    state_e                r_state;
    owner_e                r_owner;
    logic [STREAK_W-1:0]   r_streak;
    logic [WORD_SIZE-1:0]  r_address;
    logic [WORD_SIZE-1:0]  r_wdata;
    logic [WORD_SIZE-1:0]  r_if_rdata;
    logic [WORD_SIZE-1:0]  r_d_rdata;
    logic                  r_readM;
    logic                  r_writeM;
    logic                  r_data_oe;
    logic                  r_if_ready;
    logic                  r_d_ready;
    logic                  r_busy;
    logic                  r_timeout_err;

    logic   w_any_req;
    logic   w_contended;
    logic   w_streak_full;
    logic   w_active;
    logic   w_handshake;
    logic   w_grant;
    logic   w_expired;
    owner_e w_pick;
    owner_e w_pri_side;

    assign w_any_req     = bus.if_req | bus.d_req;
    assign w_contended   = bus.if_req & bus.d_req;
    assign w_streak_full = (r_streak == STREAK_W'(MAX_STREAK));
    assign w_pri_side    = DATA_PRIORITY ? OWN_D : OWN_IF;
    assign w_pick        = pick_owner(bus.if_req, bus.d_req, DATA_PRIORITY, w_streak_full);
    assign w_active      = (r_state == ST_READ) || (r_state == ST_WRITE);
    assign w_grant       = (r_state == ST_IDLE) && w_any_req;
    // A handshake on the same edge as expiry takes precedence over the abort.
    assign w_handshake   = ((r_state == ST_READ)  && bus.inputReady) ||
                           ((r_state == ST_WRITE) && bus.ackOutput);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_grant),
        .i_enable  (w_active),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_IF;
            r_streak      <= '0;
            r_address     <= '0;
            r_wdata       <= '0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_readM       <= 1'b0;
            r_writeM      <= 1'b0;
            r_data_oe     <= 1'b0;
            r_if_ready    <= 1'b0;
            r_d_ready     <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner  <= w_pick;
                        r_busy   <= 1'b1;
                        r_streak <= (w_contended && (w_pick == w_pri_side)) ?
                                    r_streak + STREAK_W'(1) : '0;
                        if (w_pick == OWN_D) begin
                            r_address <= bus.d_addr;
                            if (bus.d_we) begin
                                r_writeM  <= 1'b1;
                                r_data_oe <= 1'b1;
                                r_wdata   <= bus.d_wdata;
                                r_state   <= ST_WRITE;
                            end else begin
                                r_readM <= 1'b1;
                                r_state <= ST_READ;
                            end
                        end else begin
                            r_address <= bus.if_addr;
                            r_readM   <= 1'b1;
                            r_state   <= ST_READ;
                        end
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (w_handshake || w_expired) begin
                        r_readM   <= 1'b0;
                        r_writeM  <= 1'b0;
                        r_data_oe <= 1'b0;
                        if (r_owner == OWN_D) r_d_ready  <= 1'b1;
                        else                  r_if_ready <= 1'b1;
                        if (!w_handshake) begin
                            r_timeout_err <= 1'b1;
                            if (r_owner == OWN_D) r_d_rdata  <= '0;
                            else                  r_if_rdata <= '0;
                        end else if (r_state == ST_READ) begin
                            if (r_owner == OWN_D) r_d_rdata  <= data;
                            else                  r_if_rdata <= data;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_if_ready <= 1'b0;
                    r_d_ready  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.readM       = r_readM;
    assign bus.writeM      = r_writeM;
    assign bus.address     = r_address;
    assign bus.if_ready    = r_if_ready;
    assign bus.if_rdata    = r_if_rdata;
    assign bus.d_ready     = r_d_ready;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;
    assign data            = r_data_oe ? r_wdata : 'z;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: table of single transactions, a contention sequence and a
// mid-transaction reset, with grant/response scoreboards fed as stimulus is driven.
module tb_mem_port_arbiter;

    localparam int W = 16;

    typedef struct {
        logic         is_d;
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        int           delay;      // negedges after strobe before handshake; -1 = never
        logic [W-1:0] rdata;      // value memory returns
        int           exp_len;    // cycles the strobe is high
        logic [W-1:0] exp_rdata;
        logic         exp_err;    // timeout_err after the transaction
    } vec_t;

    typedef struct {
        logic [W-1:0] addr;
        logic         we;
        logic [W-1:0] wdata;
    } grant_t;

    typedef struct {
        logic         is_d;
        logic         we;
        logic [W-1:0] rdata;
    } resp_t;

    logic         clk;
    logic         reset;
    wire  [W-1:0] data;
    logic [W-1:0] mem_drv;
    logic         mem_oe;
    int           mem_delay;
    int           mem_cnt;
    logic [W-1:0] mem_rdata;

    int n_checks;
    int n_fail;

    grant_t grant_q[$];
    resp_t  resp_q[$];
    vec_t   vecs[9];

    logic         mon_prev_strobe;
    logic [W-1:0] mon_cur_wdata;
    grant_t       mon_g;
    resp_t        mon_r;

    mem_port_arbiter_if #(.WORD_SIZE(W)) bus ();

    mem_port_arbiter #(
        .WORD_SIZE     (W),
        .TIMEOUT       (15),
        .DATA_PRIORITY (1'b1),
        .MAX_STREAK    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .data  (data)
    );

    assign data = mem_oe ? mem_drv : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: answers the current strobe after mem_delay waiting cycles.
    initial begin
        mem_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset && (bus.readM || bus.writeM)) begin
                if (mem_delay >= 0 && mem_cnt == mem_delay) begin
                    bus.inputReady = bus.readM;
                    bus.ackOutput  = bus.writeM;
                    mem_oe         = bus.readM;
                    mem_drv        = mem_rdata;
                end else begin
                    bus.inputReady = 1'b0;
                    bus.ackOutput  = 1'b0;
                    mem_oe         = 1'b0;
                end
                mem_cnt++;
            end else begin
                mem_cnt        = 0;
                bus.inputReady = 1'b0;
                bus.ackOutput  = 1'b0;
                mem_oe         = 1'b0;
            end
        end
    end

    // Scoreboard monitor: grants checked on strobe rise, responses on ready pulses.
    initial begin
        mon_prev_strobe = 1'b0;
        mon_cur_wdata   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ((bus.readM || bus.writeM) && !mon_prev_strobe) begin
                    if (grant_q.size() == 0) begin
                        check("grant_unexpected", 32'(bus.address), 32'hFFFF_FFFF);
                    end else begin
                        mon_g = grant_q.pop_front();
                        check("grant_addr",  32'(bus.address), 32'(mon_g.addr));
                        check("grant_write", 32'(bus.writeM),  32'(mon_g.we));
                        check("grant_read",  32'(bus.readM),   32'(!mon_g.we));
                        check("grant_busy",  32'(bus.busy),    32'd1);
                        mon_cur_wdata = mon_g.wdata;
                    end
                end
                if (bus.readM || bus.writeM)
                    check("strobe_excl", 32'(bus.readM & bus.writeM), 32'd0);
                if (bus.writeM)
                    check("wdata_bus", 32'(data), 32'(mon_cur_wdata));
                if (bus.if_ready || bus.d_ready) begin
                    if (resp_q.size() == 0) begin
                        check("ready_unexpected", 32'({bus.d_ready, bus.if_ready}), 32'd0);
                    end else begin
                        mon_r = resp_q.pop_front();
                        check("ready_owner", 32'({bus.d_ready, bus.if_ready}),
                              mon_r.is_d ? 32'd2 : 32'd1);
                        if (!mon_r.we)
                            check("rdata", mon_r.is_d ? 32'(bus.d_rdata) : 32'(bus.if_rdata),
                                  32'(mon_r.rdata));
                    end
                end
            end
            mon_prev_strobe = bus.readM || bus.writeM;
        end
    end

    task automatic do_txn(input vec_t v);
        int n;
        int len;
        @(negedge clk);
        mem_delay = v.delay;
        mem_rdata = v.rdata;
        if (v.is_d) begin
            bus.d_req   = 1'b1;
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = v.addr;
        end
        grant_q.push_back(grant_t'{v.addr, v.we, v.wdata});
        resp_q.push_back(resp_t'{v.is_d, v.we, v.exp_rdata});
        n = 0;
        while (!(bus.readM || bus.writeM) && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("strobe_seen", 32'(bus.readM | bus.writeM), 32'd1);
        if (!(bus.readM || bus.writeM)) begin
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
            grant_q.delete();
            resp_q.delete();
            return;
        end
        len = 0;
        while ((bus.readM || bus.writeM) && len < 40) begin
            len++;
            @(negedge clk);
        end
        check("strobe_len", 32'(len), 32'(v.exp_len));
        check("ready_pulse", v.is_d ? 32'(bus.d_ready) : 32'(bus.if_ready), 32'd1);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", 32'(bus.if_ready | bus.d_ready), 32'd0);
        check("busy_after", 32'(bus.busy), 32'd0);
        check("timeout_err", 32'(bus.timeout_err), 32'(v.exp_err));
        if (v.we) check("data_released", 32'(data !== v.wdata), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        mem_oe   = 1'b0;
        mem_drv  = '0;
        mem_delay = -1;
        mem_rdata = '0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.inputReady = 1'b0; bus.ackOutput = 1'b0;

        //               is_d we  addr      wdata     dly rdata     len exp_rdata  err
        vecs[0] = vec_t'{1'b0, 1'b0, 16'h0010, 16'h0000,  2, 16'hA5A5,  3, 16'hA5A5, 1'b0};
        vecs[1] = vec_t'{1'b1, 1'b1, 16'h0200, 16'h1234,  3, 16'h0000,  4, 16'h0000, 1'b0};
        vecs[2] = vec_t'{1'b1, 1'b0, 16'h0300, 16'h0000,  0, 16'hBEEF,  1, 16'hBEEF, 1'b0};
        vecs[3] = vec_t'{1'b0, 1'b0, 16'hFFFF, 16'h0000,  5, 16'h0001,  6, 16'h0001, 1'b0};
        vecs[4] = vec_t'{1'b1, 1'b1, 16'h0000, 16'hFFFF, 14, 16'h0000, 15, 16'h0000, 1'b0};
        vecs[5] = vec_t'{1'b1, 1'b0, 16'h0400, 16'h0000, 14, 16'h7777, 15, 16'h7777, 1'b0};
        vecs[6] = vec_t'{1'b1, 1'b0, 16'h0500, 16'h0000, -1, 16'h9999, 15, 16'h0000, 1'b1};
        vecs[7] = vec_t'{1'b0, 1'b0, 16'h0020, 16'h0000,  1, 16'h1111,  2, 16'h1111, 1'b1};
        vecs[8] = vec_t'{1'b1, 1'b1, 16'h0600, 16'hABCD, -1, 16'h0000, 15, 16'h0000, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_readM",   32'(bus.readM),       32'd0);
        check("rst_writeM",  32'(bus.writeM),      32'd0);
        check("rst_busy",    32'(bus.busy),        32'd0);
        check("rst_err",     32'(bus.timeout_err), 32'd0);
        check("rst_ready",   32'({bus.if_ready, bus.d_ready}), 32'd0);
        check("rst_address", 32'(bus.address),     32'd0);
        check("rst_rdata",   32'({bus.if_rdata, bus.d_rdata}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) do_txn(vecs[i]);

        // Contention: both sides held, expected grant order D,D,IF,D,D,IF.
        @(negedge clk);
        mem_delay = 0;
        mem_rdata = 16'hC0DE;
        grant_q.push_back(grant_t'{16'h2000, 1'b0, 16'h0000});
        grant_q.push_back(grant_t'{16'h2001, 1'b0, 16'h0000});
        grant_q.push_back(grant_t'{16'h1000, 1'b0, 16'h0000});
        grant_q.push_back(grant_t'{16'h2002, 1'b0, 16'h0000});
        grant_q.push_back(grant_t'{16'h2003, 1'b0, 16'h0000});
        grant_q.push_back(grant_t'{16'h1001, 1'b0, 16'h0000});
        resp_q.push_back(resp_t'{1'b1, 1'b0, 16'hC0DE});
        resp_q.push_back(resp_t'{1'b1, 1'b0, 16'hC0DE});
        resp_q.push_back(resp_t'{1'b0, 1'b0, 16'hC0DE});
        resp_q.push_back(resp_t'{1'b1, 1'b0, 16'hC0DE});
        resp_q.push_back(resp_t'{1'b1, 1'b0, 16'hC0DE});
        resp_q.push_back(resp_t'{1'b0, 1'b0, 16'hC0DE});
        bus.if_req = 1'b1; bus.if_addr = 16'h1000;
        bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h2000;
        for (int k = 0; k < 6; k++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(bus.if_ready || bus.d_ready) && n < 30);
            if (!(bus.if_ready || bus.d_ready)) begin
                check("contention_ready", 32'(bus.if_ready | bus.d_ready), 32'd1);
                break;
            end
            if (bus.d_ready) bus.d_addr  = bus.d_addr + 16'd1;
            else             bus.if_addr = bus.if_addr + 16'd1;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (4) @(negedge clk);
        check("contention_drain", 32'(grant_q.size() + resp_q.size()), 32'd0);
        grant_q.delete();
        resp_q.delete();

        // Reset in the middle of a read: transaction abandoned, no ready pulse.
        mem_delay  = -1;
        bus.if_req = 1'b1;
        bus.if_addr = 16'h0040;
        grant_q.push_back(grant_t'{16'h0040, 1'b0, 16'h0000});
        resp_q.push_back(resp_t'{1'b0, 1'b0, 16'h0000});
        begin
            int n;
            n = 0;
            while (!bus.readM && n < 8) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_mid_readM_up", 32'(bus.readM), 32'd1);
        repeat (2) @(negedge clk);
        reset      = 1'b1;
        bus.if_req = 1'b0;
        resp_q.delete();
        @(negedge clk);
        check("mid_rst_strobes", 32'({bus.readM, bus.writeM}), 32'd0);
        check("mid_rst_busy",    32'(bus.busy),        32'd0);
        check("mid_rst_err",     32'(bus.timeout_err), 32'd0);
        check("mid_rst_address", 32'(bus.address),     32'd0);
        check("mid_rst_rdata",   32'({bus.if_rdata, bus.d_rdata}), 32'd0);
        check("mid_rst_ready",   32'({bus.if_ready, bus.d_ready}), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_idle", 32'({bus.busy, bus.if_ready, bus.d_ready}), 32'd0);
        grant_q.delete();
        do_txn(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
